// File: rtl/cla_seq_add_ctrl.sv
// cla_seq_add_ctrl
//   Adds two TOTAL_W-bit operands by passing them through one DATA_WIDTH-bit
//   carry_gen_adder slice, one slice per clock, least significant slice
//   first. A registered carry links each slice to the next, so a wide add
//   costs NUM_SLICES cycles but needs only one narrow CLA.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operand request handshake; a, b, cin sampled on accept
//   a, b, cin       TOTAL_W-bit operands and carry-in
//   out_valid/ready result handshake
//   sum, cout       registered TOTAL_W-bit result and final carry-out
//   busy            high while an operation is in RUN or DONE
//   o_dbg_state     current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its data until that edge. in_ready
// is high only in IDLE outside reset. out_valid stays high, with sum/cout
// frozen, until the consumer takes the result.

module carry_gen_adder #(
  parameter int data_width = 4
) (
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic                  cin,
  output logic [data_width-1:0] sum,
  output logic                  cout
);
  logic [data_width-1:0] w_g;
  logic [data_width-1:0] w_p;
  logic [data_width:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is a generate/propagate recurrence. The loop unrolls into a
  // flat product-of-terms per carry bit, which gives the lookahead structure.
  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < data_width; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign sum  = w_p ^ w_c[data_width-1:0];
  assign cout = w_c[data_width];
endmodule

module cla_seq_add_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_SLICES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*NUM_SLICES-1:0] a,
  input  logic [DATA_WIDTH*NUM_SLICES-1:0] b,
  input  logic                             cin,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*NUM_SLICES-1:0] sum,
  output logic                             cout,
  output logic                             busy,
  output logic [1:0]                       o_dbg_state
);
  localparam int TOTAL_W = DATA_WIDTH * NUM_SLICES;
  localparam int IDX_W   = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic [TOTAL_W-1:0]  r_a;
  logic [TOTAL_W-1:0]  r_b;
  logic [TOTAL_W-1:0]  r_sum;
  logic                r_cout;
  logic                r_out_valid;

  logic [DATA_WIDTH-1:0] w_slice_a;
  logic [DATA_WIDTH-1:0] w_slice_b;
  logic [DATA_WIDTH-1:0] w_slice_sum;
  logic                  w_slice_cout;
  logic                  w_accept;
  logic                  w_last;

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_last      = (r_idx == IDX_W'(NUM_SLICES - 1));
  assign out_valid   = r_out_valid;
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

  // Slice inputs come from the operand registers, never the ports, so they
  // only change on clock edges. Outside RUN their value is unused.
  assign w_slice_a = r_a[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_slice_b = r_b[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];

  carry_gen_adder #(.data_width(DATA_WIDTH)) u_slice (
    w_slice_a, w_slice_b, r_carry, w_slice_sum, w_slice_cout
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        S_RUN: begin
          r_sum[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] <= w_slice_sum;
          r_carry <= w_slice_cout;
          if (w_last) begin
            r_cout      <= w_slice_cout;
            r_out_valid <= 1'b1;
            r_idx       <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end
endmodule
